// File: rtl/mnist_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mnist_layer_scheduler
// Brief    : Launches each network layer in order behind a per-layer watchdog,
//            then scans the final digit scores for the winning class.
// Revision : 1.0 - initial release
// ============================================================================
module mnist_layer_scheduler #(
    parameter int NUM_LAYERS     = 3,
    parameter int NUM_CLASSES    = 10,
    parameter int SCORE_W        = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [NUM_LAYERS-1:0]          layer_start,
    input  logic [NUM_LAYERS-1:0]          layer_done,
    output logic                           buf_sel,
    input  logic [NUM_CLASSES*SCORE_W-1:0] digit_scores,
    output logic [3:0]                     predicted_digit,
    output logic [SCORE_W-1:0]             max_score,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout
);

    localparam int c_LW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_LW-1:0]       c_LAST_LAYER = c_LW'(NUM_LAYERS - 1);
    localparam logic [3:0]            c_LAST_IDX   = 4'(NUM_CLASSES - 1);
    localparam logic [NUM_LAYERS-1:0] c_LAYER_ONE  = NUM_LAYERS'(1);
    localparam logic [c_WDOG_W-1:0]   c_WDOG_MAX   = c_WDOG_W'(TIMEOUT_CYCLES);
    localparam logic [c_WDOG_W:0]     c_WDOG_LIMIT = (c_WDOG_W + 1)'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ARGMAX = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]            r_state;
    logic [c_LW-1:0]       r_layer;
    logic [c_WDOG_W-1:0]   r_wdog;
    logic [3:0]            r_idx;
    logic [NUM_LAYERS-1:0] r_layer_start;
    logic                  r_buf_sel;
    logic [3:0]            r_best;
    logic [SCORE_W-1:0]    r_max;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timeout;

    logic [c_LW-1:0]       w_next_layer;
    logic [c_WDOG_W:0]     w_wdog_inc;
    logic                  w_wdog_hit;
    logic [SCORE_W-1:0]    w_score;

    assign w_next_layer = r_layer + 1'b1;
    assign w_wdog_inc   = {1'b0, r_wdog} + 1'b1;
    assign w_wdog_hit   = (w_wdog_inc >= c_WDOG_LIMIT);
    assign w_score      = digit_scores[r_idx*SCORE_W +: SCORE_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_layer       <= '0;
            r_wdog        <= '0;
            r_idx         <= '0;
            r_layer_start <= '0;
            r_buf_sel     <= 1'b0;
            r_best        <= '0;
            r_max         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_layer_start <= '0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_LAUNCH;
                        r_layer       <= '0;
                        r_buf_sel     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_layer_start <= c_LAYER_ONE;
                    end
                end
                S_LAUNCH: begin
                    // The launch-pulse cycle is elapsed cycle 1 of this layer's budget.
                    r_wdog  <= c_WDOG_W'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (layer_done[r_layer]) begin
                        r_buf_sel <= ~r_buf_sel;
                        if (r_layer == c_LAST_LAYER) begin
                            r_state <= S_ARGMAX;
                            r_idx   <= '0;
                            r_max   <= '0;
                            r_best  <= '0;
                        end else begin
                            r_layer       <= w_next_layer;
                            r_layer_start <= c_LAYER_ONE << w_next_layer;
                            r_state       <= S_LAUNCH;
                        end
                    end else if (w_wdog_hit) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (r_wdog != c_WDOG_MAX) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    // >= lets a later equal score take over, so ties pick the highest index.
                    if (w_score >= r_max) begin
                        r_max  <= w_score;
                        r_best <= r_idx;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_ERR: begin
                    r_timeout <= 1'b1;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign layer_start     = r_layer_start;
    assign buf_sel         = r_buf_sel;
    assign predicted_digit = r_best;
    assign max_score       = r_max;
    assign busy            = r_busy;
    assign done            = r_done;
    assign timeout         = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mnist_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mnist_layer_scheduler
// Brief    : Directed and randomized checks of the layer scheduler against an
//            array-based reference of the sequencing and argmax rules.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mnist_layer_scheduler;

    localparam int NL  = 3;
    localparam int NC  = 10;
    localparam int SW  = 16;
    localparam int TMO = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NL-1:0]    layer_start;
    logic [NL-1:0]    layer_done;
    logic             buf_sel;
    logic [NC*SW-1:0] digit_scores;
    logic [3:0]       predicted_digit;
    logic [SW-1:0]    max_score;
    logic             busy;
    logic             done;
    logic             timeout;

    logic [SW-1:0] sc [NC];
    int            n_cmp  = 0;
    int            n_fail = 0;
    int            pulses [NL];
    int            start_left = 0;
    int            lat [NL];
    logic [3:0]    exp_idx, prev_idx;
    logic [SW-1:0] exp_max, prev_max;

    mnist_layer_scheduler #(
        .NUM_LAYERS     (NL),
        .NUM_CLASSES    (NC),
        .SCORE_W        (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .layer_start     (layer_start),
        .layer_done      (layer_done),
        .buf_sel         (buf_sel),
        .digit_scores    (digit_scores),
        .predicted_digit (predicted_digit),
        .max_score       (max_score),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        digit_scores = '0;
        for (int i = 0; i < NC; i++) digit_scores[i*SW +: SW] = sc[i];
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) if (layer_start[i]) pulses[i]++;
        if (start_left > 0) start_left--;
        start = (start_left > 0);
    endtask

    // Reference argmax: largest value first, then the last index holding it.
    task automatic ref_argmax(output logic [3:0] idx, output logic [SW-1:0] mx);
        int best;
        mx = '0;
        for (int i = 0; i < NC; i++) if (sc[i] > mx) mx = sc[i];
        best = 0;
        for (int i = 0; i < NC; i++) if (sc[i] == mx) best = i;
        idx = 4'(best);
    endtask

    // Called in layer k's launch cycle; returns in the cycle after layer_done[k].
    task automatic serve_layer(input int k, input int latency, input bit strays);
        logic [NL-1:0] own;
        own = NL'(1) << k;
        check($sformatf("launch_onehot_l%0d", k), 32'(layer_start), 32'(own));
        check($sformatf("buf_sel_l%0d", k), 32'(buf_sel), 32'(k % 2));
        layer_done = strays ? NL'($urandom) : '0;
        for (int c = 1; c < latency; c++) begin
            tick();
            layer_done = strays ? (NL'($urandom) & ~own) : '0;
        end
        tick();
        layer_done = own | (strays ? NL'($urandom) : '0);
        tick();
        layer_done = '0;
    endtask

    task automatic launch_layers(input int start_len, input bit strays);
        for (int i = 0; i < NL; i++) pulses[i] = 0;
        start_left = start_len;
        start = 1'b1;
        tick();
        for (int k = 0; k < NL; k++) serve_layer(k, lat[k], strays);
    endtask

    task automatic finish_run(input string tag);
        int n;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ref_argmax(exp_idx, exp_max);
        check({tag, "_done_latency"}, 32'(n), 32'(NC + 1));
        check({tag, "_digit"}, 32'(predicted_digit), 32'(exp_idx));
        check({tag, "_max"}, 32'(max_score), 32'(exp_max));
        check({tag, "_buf_sel_end"}, 32'(buf_sel), 32'(NL % 2));
        check({tag, "_busy_end"}, 32'(busy), 32'(0));
        check({tag, "_timeout"}, 32'(timeout), 32'(0));
        for (int i = 0; i < NL; i++)
            check($sformatf("%s_pulses_l%0d", tag, i), 32'(pulses[i]), 32'(1));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        layer_done = '0;
        for (int i = 0; i < NC; i++) sc[i] = '0;
        repeat (3) tick();
        check("reset_outputs", 32'({layer_start, buf_sel, predicted_digit, max_score, busy, done, timeout}), 32'(0));
        rst = 1'b0;
        tick();

        // Basic run with the reference score set (unsigned compare).
        sc = '{16'h0010, 16'h0200, 16'h7FFF, 16'h0001, 16'hFFFF,
               16'h0000, 16'h1234, 16'h0FFF, 16'h0002, 16'h0003};
        lat = '{50, 50, 50};
        launch_layers(2, 1'b0);
        finish_run("basic");
        check("basic_digit_is_4", 32'(predicted_digit), 32'(4));
        prev_idx = predicted_digit;
        prev_max = max_score;
        repeat (5) tick();
        check("done_holds", 32'({done, busy}), 32'(2'b10));

        // Restart directly from DONE gives the same answer.
        launch_layers(1, 1'b0);
        finish_run("restart");
        check("restart_same_digit", 32'(predicted_digit), 32'(prev_idx));
        check("restart_same_max", 32'(max_score), 32'(prev_max));

        // All-zero scores: the tie chain ends on the last digit.
        for (int i = 0; i < NC; i++) sc[i] = '0;
        lat = '{3, 1, 7};
        launch_layers(1, 1'b1);
        finish_run("zeros");

        // Digits 3 and 7 tie at the top.
        for (int i = 0; i < NC; i++) sc[i] = 16'($urandom_range(0, 16'h3FFF));
        sc[3] = 16'h4000;
        sc[7] = 16'h4000;
        lat = '{10, 20, 5};
        launch_layers(1, 1'b1);
        finish_run("tie");

        // Layer 0 answers in the very cycle its watchdog would expire.
        lat = '{TMO - 1, 12, TMO - 1};
        for (int i = 0; i < NC; i++) sc[i] = 16'($urandom);
        launch_layers(1, 1'b1);
        finish_run("edge_timeout");

        // Randomized runs with stray handshakes and occasional duplicated maxima.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NC; i++) sc[i] = 16'($urandom);
            if (r % 2 == 1) sc[$urandom_range(0, NC - 1)] = sc[$urandom_range(0, NC - 1)];
            for (int k = 0; k < NL; k++) lat[k] = $urandom_range(1, TMO - 1);
            launch_layers($urandom_range(1, 3), 1'b1);
            finish_run($sformatf("rand%0d", r));
        end

        // Reset in the middle of the argmax scan.
        for (int i = 0; i < NC; i++) sc[i] = 16'($urandom_range(1, 16'hFFFF));
        lat = '{4, 4, 4};
        launch_layers(1, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_argmax", 32'({layer_start, buf_sel, predicted_digit, max_score, busy, done, timeout}), 32'(0));
        rst = 1'b0;
        repeat (15) tick();
        check("idle_after_rst", 32'({busy, done}), 32'(0));

        // Watchdog: layer 1 never completes.
        for (int i = 0; i < NL; i++) pulses[i] = 0;
        start_left = 1;
        start = 1'b1;
        tick();
        serve_layer(0, 30, 1'b0);
        check("wd_launch_l1", 32'(layer_start), 32'(3'b010));
        begin
            int n;
            n = 0;
            while (timeout !== 1'b1 && n < 300) begin
                tick();
                n++;
            end
            check("wd_timeout_latency", 32'(n), 32'(TMO));
        end
        check("wd_busy_done", 32'({busy, done}), 32'(0));
        start_left = 2;
        start = 1'b1;
        repeat (10) tick();
        check("wd_start_ignored", 32'(pulses[0] + pulses[1] + pulses[2]), 32'(2));
        check("wd_sticky", 32'({timeout, busy, done}), 32'(3'b100));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wd_rst_clears", 32'(timeout), 32'(0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
